// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared voice-path types, widths and CIC sizing helper
package voice_pkg;

  localparam int PCM_W     = 16;
  localparam int CIC_ORDER = 3;

  typedef logic signed [PCM_W-1:0] pcm_t;

  // Integrator width needed so an order-N CIC with decimation decim never
  // loses information after wrap-around: 2 guard bits + N*log2(decim).
  function automatic int cic_acc_w(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_decimator_if.sv
// rtl/pdm_decimator_if.sv - PCM sample stream with valid/ready handshake
interface pdm_decimator_if;
  import voice_pkg::*;

  pcm_t sample;
  logic sample_valid;
  logic sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/pdm_clkgen.sv
// rtl/pdm_clkgen.sv - PDM microphone clock divider and bit-capture strobe
module pdm_clkgen #(
  parameter int CLK_DIV = 40
) (
  input  logic clk,
  input  logic reset_L,
  input  logic enable,
  output logic micClk,
  output logic bit_stb
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          mic_clk_q, mic_clk_d;

  // Next divider count; micClk is derived from the next count so it lines up with div_cnt
  always_comb begin
    div_cnt_d = '0;
    if (enable) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
    end
    mic_clk_d = enable && (div_cnt_d >= HALF);
  end

  // Divider and clock-output registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      div_cnt_q <= '0;
      mic_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mic_clk_q <= mic_clk_d;
    end
  end

  assign micClk  = mic_clk_q;
  // Last cycle of the high phase: data from the mic is stable here
  assign bit_stb = enable && (div_cnt_q == LAST);

endmodule

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - PDM capture, 3rd-order CIC decimator and PCM holding register
module pdm_decimator
  import voice_pkg::*;
#(
  parameter int CLK_DIV = 40,
  parameter int DECIM   = 64
) (
  input  logic clk,
  input  logic reset_L,
  input  logic enable,
  input  logic micData,
  output logic micClk,
  output logic overrun,
  pdm_decimator_if.master pcm
);

  localparam int ACC_W = cic_acc_w(DECIM);
  // Full scale DECIM^3 = 2^(ACC_W-2) is brought to 2^15 before saturation
  localparam int SHR = (ACC_W > 17) ? ACC_W - 17 : 0;
  localparam int SHL = (ACC_W < 17) ? 17 - ACC_W : 0;
  localparam int DW  = $clog2(DECIM);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  typedef logic signed [ACC_W-1:0] acc_t;
  localparam acc_t PLUS1  = acc_t'(1);
  localparam acc_t MINUS1 = '1;

  logic          bit_stb;
  logic [DW-1:0] dec_cnt_q;
  acc_t          i1_q, i2_q, i3_q;
  acc_t          d1_q, d2_q, d3_q;
  acc_t          x, c1, c2, c3;
  logic          frame_q;
  logic [1:0]    warm_q;
  logic          new_sample;
  logic signed [31:0] wide, scaled;
  pcm_t          pcm_d;
  pcm_t          sample_q;
  logic          valid_q, overrun_q;

  pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk     (clk),
    .reset_L (reset_L),
    .enable  (enable),
    .micClk  (micClk),
    .bit_stb (bit_stb)
  );

  // Bit mapping, comb chain on the latest integrator-3 value, scale and saturate
  always_comb begin
    x      = micData ? PLUS1 : MINUS1;
    c1     = i3_q - d1_q;
    c2     = c1 - d2_q;
    c3     = c2 - d3_q;
    wide   = {{(32 - ACC_W){c3[ACC_W-1]}}, c3};
    scaled = (wide >>> SHR) <<< SHL;
    if (scaled > 32'sd32767) begin
      pcm_d = 16'sh7fff;
    end else if (scaled < -32'sd32768) begin
      pcm_d = 16'sh8000;
    end else begin
      pcm_d = pcm_t'(scaled[PCM_W-1:0]);
    end
  end

  // Only the fourth and later comb outputs after a (re)start carry a settled value
  assign new_sample = frame_q && (warm_q == 2'd3);

  // Integrators and frame counter step on capture cycles; combs and warm-up step on frame wraps
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      dec_cnt_q <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      frame_q   <= 1'b0;
      warm_q    <= 2'd0;
    end else if (!enable) begin
      dec_cnt_q <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      frame_q   <= 1'b0;
      warm_q    <= 2'd0;
    end else begin
      if (bit_stb) begin
        i1_q      <= i1_q + x;
        i2_q      <= i2_q + i1_q;
        i3_q      <= i3_q + i2_q;
        dec_cnt_q <= dec_cnt_q + DW'(1);
      end
      frame_q <= bit_stb && (dec_cnt_q == DEC_LAST);
      if (frame_q) begin
        d1_q <= i3_q;
        d2_q <= c1;
        d3_q <= c2;
        if (warm_q != 2'd3) begin
          warm_q <= warm_q + 2'd1;
        end
      end
    end
  end

  // Holding register: a new sample always wins; overwriting an unconsumed one flags overrun
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!enable) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (new_sample) begin
      sample_q <= pcm_d;
      valid_q  <= 1'b1;
      if (valid_q && !pcm.sample_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (valid_q && pcm.sample_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign pcm.sample       = sample_q;
  assign pcm.sample_valid = valid_q;
  assign overrun          = overrun_q;

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Front end of the voice path, directly upstream of `SpeechRecog`. It generates the PDM microphone clock, samples the 1-bit `micData` stream, and runs it through a 3rd-order CIC decimator. The result is a stream of signed 16-bit PCM samples presented on a valid/ready handshake. `micLRSel` is tied low at top level, so the block only ever captures the left channel.

## Interface
- `CLK_DIV`, default 40: `clk` cycles per `micClk` period; even, ≥4 (100 MHz → 2.5 MHz).
- `DECIM`, default 64: PDM bits per PCM sample; power of two, 4..256.
- `clk` in 1: system clock.
- `reset_L` in 1: one clock; reset is asynchronous and active-low.
- `enable` in 1: capture enable, level-sensitive.
- `micData` in 1: PDM data from the microphone.
- `micClk` out 1: PDM clock to the microphone.
- `sample` out 16: signed PCM sample.
- `sample_valid` out 1: `sample` holds an unconsumed value.
- `sample_ready` in 1: the consumer takes the sample on any cycle with valid && ready.
- `overrun` out 1: sticky flag; an unconsumed sample was overwritten.

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1 and wraps while `enable` is high.
  - `micClk` is a register equal to (div_cnt ≥ CLK_DIV/2).
- **Bit capture.**
  - `micData` is sampled in the cycle where div_cnt == CLK_DIV-1, the last cycle of the high phase.
  - A sampled 1 maps to +1 and a sampled 0 maps to −1.
- **CIC integrators.** Three cascaded integrators, each ACC_W = 2 + 3·log2(DECIM) bits wide (20 at default), two's complement.
  - Wrap-around is intentional; there is no saturation inside the CIC.
  - The integrators update only on bit-capture cycles.
- **Frame counter.** `dec_cnt` counts captured bits 0..DECIM-1.
  - At each wrap, the integrator-3 value feeds 3 comb stages (differential delay 1), which update only at frame wraps.
- **Scaling.**
  - Comb output range is ±DECIM³.
  - Shift arithmetically right by ACC_W-17 bits (3 at default), then saturate to [−32768, 32767].
- **Warm-up.** The first 3 comb outputs after reset or enable rise are discarded; a 2-bit warm-up counter tracks this.
- **Holding register and handshake.**
  - A new output loads `sample` and sets `sample_valid`.
  - valid && ready with no new sample in the same cycle clears valid.
  - A new sample arriving while valid && !ready overwrites `sample` and sets `overrun`.
  - A new sample arriving in the same cycle as valid && ready loads normally, keeps valid high, and does not set `overrun`.
- **enable = 0.**
  - Synchronously clears div_cnt, dec_cnt, integrators, combs, the warm-up counter, `micClk`, `sample_valid` and `overrun`.
  - `sample` holds its last value.
- **Mid-frame events.** Reset or `enable` low in the middle of a frame discards the partial frame. The next frame starts from dec_cnt = 0 with warm-up re-armed.

## Timing
- **Reset values.** All outputs 0: `micClk`=0, `sample`=0, `sample_valid`=0, `overrun`=0.
- **micClk start.** The first rising edge of `micClk` is visible CLK_DIV/2 cycles after the first cycle with `enable` high.
- **Output latency.**
  - Let T be the capture cycle of the last bit of a frame.
  - The integrators are registered at the end of T.
  - The comb/scale result is registered at the end of T+1.
  - `sample_valid` rises in cycle T+2.
- **Output rate.** One sample per CLK_DIV·DECIM cycles (2560 at defaults, 39.0625 kHz at 100 MHz).
- **Handshake.** `sample_ready` is combinational-free; `sample_valid` does not depend on `sample_ready` within a cycle.

## Structure
- **Shared package.** `voice_pkg` holds:
  - `PCM_W`=16 and `CIC_ORDER`=3;
  - `typedef logic signed [PCM_W-1:0] pcm_t`;
  - a `cic_acc_w(decim)` function used to size ACC_W.
- **Sub-module.** `pdm_clkgen` contains the divider. It outputs `micClk` and a one-cycle `bit_stb` at div_cnt == CLK_DIV-1.
- **Top body.** The CIC, warm-up logic and holding register remain in the `pdm_decimator` body.

## Test plan
- **Reset and idle.** Assert `reset_L`=0 with `enable`=0 → all outputs 0 and `micClk` stays low over 1000 cycles.
- **All ones.** `micData`=1, `enable`=1, `sample_ready`=1 → `micClk` period is 40 cycles. The first 3 frames produce no valid. From then on, `sample`=32767 (saturated) with valid pulses every 2560 cycles.
- **All zeros.** `micData`=0 → steady `sample` = −32768 exactly after warm-up.
- **Alternating bits.** Alternating 1/0 per `micClk` → `sample` = 0 after warm-up. A 3-ones:1-zero pattern → `sample` = 16384.
- **Backpressure.**
  - `sample_ready`=0 across two frame outputs → `overrun`=1, `sample_valid`=1, and `sample` is the second value.
  - Ready asserted on exactly the cycle a new sample lands → no overrun, valid stays 1.
- **Mid-frame disable.** Drop `enable` at dec_cnt=30 → next cycle `micClk`=0, `sample_valid`=0, `overrun`=0. Re-enable → 3 discarded frames, then correct values. Repeat using an async `reset_L` pulse landing between `clk` edges.
